// File: rtl/conv_mac_seq.sv
// Row-serial KxK convolution MAC: accepts one window plus its coefficient set, accumulates one kernel row per cycle,
// then rounds, shifts, optionally applies ReLU, saturates, and holds the result under valid/ready.
module conv_mac_seq #(
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    win_valid,
    output logic                    win_ready,
    input  logic [K*K*DATA_W-1:0]   window_in,
    input  logic [K*K*COEF_W-1:0]   coef_in,
    input  logic                    relu_en,
    output logic                    shift_buffer,
    output logic [OUT_W-1:0]        result,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    busy
);

    localparam int ACC_W   = DATA_W + COEF_W + $clog2(K*K) + 1;
    localparam int PROD_W  = DATA_W + COEF_W + 1;
    localparam int ROW_W   = $clog2(K);
    localparam int SAT_W   = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int RND_BIT = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [ACC_W-1:0] RND     = (SHIFT > 0) ? (ACC_W'(1) << RND_BIT) : '0;
    localparam logic signed [SAT_W-1:0] SAT_MAX = SAT_W'({(OUT_W-1){1'b1}});
    localparam logic signed [SAT_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_OUT
    } state_e;

    state_e                    state_q, state_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [K*K*DATA_W-1:0]     win_q, win_d;
    logic [K*K*COEF_W-1:0]     coef_q, coef_d;
    logic                      relu_q, relu_d;
    logic [OUT_W-1:0]          result_q, result_d;
    logic                      result_valid_q, result_valid_d;
    logic                      shift_buffer_q, shift_buffer_d;

    logic [DATA_W-1:0]         pix;
    logic [COEF_W-1:0]         cf;
    logic signed [PROD_W-1:0]  pix_s, coef_s, prod;
    logic signed [ACC_W-1:0]   row_sum;
    logic signed [ACC_W-1:0]   rnd_sum, shifted, v;
    logic signed [SAT_W-1:0]   v_ext;
    logic [OUT_W-1:0]          res_sat;
    int unsigned               base;

    // Pixels are unsigned, so they enter the product with a zero sign bit.
    always_comb begin
        row_sum = '0;
        pix     = '0;
        cf      = '0;
        pix_s   = '0;
        coef_s  = '0;
        prod    = '0;
        base    = 0;
        for (int unsigned c = 0; c < K; c++) begin
            base    = 32'(row_q) * K + c;
            pix     = win_q[base*DATA_W +: DATA_W];
            cf      = coef_q[base*COEF_W +: COEF_W];
            pix_s   = {{(PROD_W-DATA_W){1'b0}}, pix};
            coef_s  = {{(PROD_W-COEF_W){cf[COEF_W-1]}}, cf};
            prod    = pix_s * coef_s;
            row_sum = row_sum + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

    always_comb begin
        rnd_sum = acc_q + RND;
        shifted = rnd_sum >>> SHIFT;
        v       = shifted;
        if (relu_q && shifted[ACC_W-1]) begin
            v = '0;
        end
        v_ext = SAT_W'(v);
        if (v_ext > SAT_MAX) begin
            res_sat = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (v_ext < SAT_MIN) begin
            res_sat = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            res_sat = v_ext[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d        = state_q;
        row_d          = row_q;
        acc_d          = acc_q;
        win_d          = win_q;
        coef_d         = coef_q;
        relu_d         = relu_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        shift_buffer_d = 1'b0;
        win_ready      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                win_ready = 1'b1;
                if (win_valid) begin
                    win_d          = window_in;
                    coef_d         = coef_in;
                    relu_d         = relu_en;
                    acc_d          = '0;
                    row_d          = '0;
                    shift_buffer_d = 1'b1;
                    state_d        = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + row_sum;
                row_d = row_q + ROW_W'(1);
                if (row_q == ROW_W'(K-1)) begin
                    row_d   = '0;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                // First OUT cycle captures the final accumulator; afterwards hold until the handshake.
                if (!result_valid_q) begin
                    result_d       = res_sat;
                    result_valid_d = 1'b1;
                end else if (result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            row_q          <= '0;
            acc_q          <= '0;
            win_q          <= '0;
            coef_q         <= '0;
            relu_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            shift_buffer_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            acc_q          <= acc_d;
            win_q          <= win_d;
            coef_q         <= coef_d;
            relu_q         <= relu_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            shift_buffer_q <= shift_buffer_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign shift_buffer = shift_buffer_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
